// File: rtl/r16_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// r16_mem_access_ctrl : two-bank memory responder for the radix-16 FFT AGU.
// Reads, in-order address FIFO, in-place write-back, one-entry read skid.
// Revision: 1.0
// ============================================================================
module r16_mem_access_ctrl #(
  parameter int A_WIDTH    = 11,
  parameter int D_WIDTH    = 64,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        agu_valid,
  input  logic                        BN_in,
  input  logic [A_WIDTH-1:0]          MA_in,
  input  logic                        pe_out_valid,
  input  logic [D_WIDTH-1:0]          pe_out_data,
  input  logic [D_WIDTH-1:0]          bank0_rdata,
  input  logic [D_WIDTH-1:0]          bank1_rdata,
  output logic                        bank0_cen,
  output logic                        bank0_wen,
  output logic [A_WIDTH-1:0]          bank0_addr,
  output logic [D_WIDTH-1:0]          bank0_wdata,
  output logic                        bank1_cen,
  output logic                        bank1_wen,
  output logic [A_WIDTH-1:0]          bank1_addr,
  output logic [D_WIDTH-1:0]          bank1_wdata,
  output logic                        rd_valid,
  output logic [D_WIDTH-1:0]          rd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        ovf_err,
  output logic                        unf_err,
  output logic [CNT_WIDTH-1:0]        conflict_cnt
);

  localparam int             PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic                 fifo_bn [FIFO_DEPTH];
  logic [A_WIDTH-1:0]   fifo_ma [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;

  logic                 skid_valid;
  logic                 skid_bn;
  logic [A_WIDTH-1:0]   skid_ma;
  logic                 skid_valid_nxt;
  logic                 skid_bn_nxt;
  logic [A_WIDTH-1:0]   skid_ma_nxt;

  logic                 rd_pending;
  logic                 rd_bn;
  logic [D_WIDTH-1:0]   rd_hold;
  logic [D_WIDTH-1:0]   rd_mux;

  logic                 ovf_q;
  logic                 unf_q;
  logic [CNT_WIDTH-1:0] conflict_q;

  logic                 head_bn;
  logic [A_WIDTH-1:0]   head_ma;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 cand_valid;
  logic                 cand_bn;
  logic [A_WIDTH-1:0]   cand_ma;
  logic                 conflict;
  logic                 room;
  logic                 issue;
  logic                 ovf_set;
  logic                 unf_set;
  logic                 defer;

  // Decisions are gated by rst_n so the bank enables drop the instant reset asserts.
  always_comb begin
    head_bn    = fifo_bn[rd_ptr];
    head_ma    = fifo_ma[rd_ptr];
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    pop        = rst_n & pe_out_valid & ~fifo_empty;
    unf_set    = pe_out_valid & fifo_empty;
    cand_valid = rst_n & (skid_valid | agu_valid);
    cand_bn    = skid_valid ? skid_bn : BN_in;
    cand_ma    = skid_valid ? skid_ma : MA_in;
    conflict   = pop & cand_valid & (head_bn == cand_bn);
    room       = ~fifo_full | pop;
    issue      = cand_valid & ~conflict & room;
  end

  // A conflict needs a pop, and a pop always frees room, so a blocked
  // candidate is blocked either by conflict or by a full FIFO, never both.
  always_comb begin
    skid_valid_nxt = skid_valid;
    skid_bn_nxt    = skid_bn;
    skid_ma_nxt    = skid_ma;
    ovf_set        = 1'b0;
    defer          = 1'b0;
    if (skid_valid) begin
      if (issue) begin
        skid_valid_nxt = agu_valid;
        skid_bn_nxt    = BN_in;
        skid_ma_nxt    = MA_in;
      end else if (conflict) begin
        ovf_set = agu_valid;
      end else begin
        skid_valid_nxt = 1'b0;
        ovf_set        = 1'b1;
      end
    end else if (agu_valid && !issue) begin
      if (conflict) begin
        skid_valid_nxt = 1'b1;
        skid_bn_nxt    = BN_in;
        skid_ma_nxt    = MA_in;
        defer          = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  always_comb begin
    bank0_cen   = 1'b0;
    bank0_wen   = 1'b0;
    bank0_addr  = '0;
    bank0_wdata = '0;
    bank1_cen   = 1'b0;
    bank1_wen   = 1'b0;
    bank1_addr  = '0;
    bank1_wdata = '0;
    if (pop) begin
      if (!head_bn) begin
        bank0_cen   = 1'b1;
        bank0_wen   = 1'b1;
        bank0_addr  = head_ma;
        bank0_wdata = pe_out_data;
      end else begin
        bank1_cen   = 1'b1;
        bank1_wen   = 1'b1;
        bank1_addr  = head_ma;
        bank1_wdata = pe_out_data;
      end
    end
    if (issue) begin
      if (!cand_bn) begin
        bank0_cen  = 1'b1;
        bank0_addr = cand_ma;
      end else begin
        bank1_cen  = 1'b1;
        bank1_addr = cand_ma;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      fifo_bn[wr_ptr] <= cand_bn;
      fifo_ma[wr_ptr] <= cand_ma;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      skid_valid <= 1'b0;
      skid_bn    <= 1'b0;
      skid_ma    <= '0;
      rd_pending <= 1'b0;
      rd_bn      <= 1'b0;
      rd_hold    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      conflict_q <= '0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      skid_valid <= skid_valid_nxt;
      skid_bn    <= skid_bn_nxt;
      skid_ma    <= skid_ma_nxt;
      rd_pending <= issue;
      if (issue)      rd_bn   <= cand_bn;
      if (rd_pending) rd_hold <= rd_mux;
      if (ovf_set)    ovf_q   <= 1'b1;
      if (unf_set)    unf_q   <= 1'b1;
      if (defer && (conflict_q != {CNT_WIDTH{1'b1}}))
        conflict_q <= conflict_q + 1'b1;
    end
  end

  // SRAM data arrives the cycle after issue; hold the last word otherwise.
  always_comb begin
    rd_mux       = rd_bn ? bank1_rdata : bank0_rdata;
    rd_valid     = rd_pending;
    rd_data      = rd_pending ? rd_mux : rd_hold;
    fifo_cnt     = count;
    ovf_err      = ovf_q;
    unf_err      = unf_q;
    conflict_cnt = conflict_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_r16_mem_access_ctrl.sv
`default_nettype none
// Bench for r16_mem_access_ctrl: directed scenarios then random traffic,
// checked against a queue-based request model and a shadow memory.
module tb_r16_mem_access_ctrl;

  localparam int DEPTH = 32;
  localparam int CMAX  = 15;

  typedef struct packed {
    logic        bn;
    logic [10:0] ma;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        agu_valid;
  logic        BN_in;
  logic [10:0] MA_in;
  logic        pe_out_valid;
  logic [63:0] pe_out_data;
  logic [63:0] bank0_rdata;
  logic [63:0] bank1_rdata;
  logic        bank0_cen, bank0_wen, bank1_cen, bank1_wen;
  logic [10:0] bank0_addr, bank1_addr;
  logic [63:0] bank0_wdata, bank1_wdata;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic [5:0]  fifo_cnt;
  logic        ovf_err, unf_err;
  logic [3:0]  conflict_cnt;

  r16_mem_access_ctrl #(
    .A_WIDTH(11), .D_WIDTH(64), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .agu_valid(agu_valid), .BN_in(BN_in), .MA_in(MA_in),
    .pe_out_valid(pe_out_valid), .pe_out_data(pe_out_data),
    .bank0_rdata(bank0_rdata), .bank1_rdata(bank1_rdata),
    .bank0_cen(bank0_cen), .bank0_wen(bank0_wen), .bank0_addr(bank0_addr), .bank0_wdata(bank0_wdata),
    .bank1_cen(bank1_cen), .bank1_wen(bank1_wen), .bank1_addr(bank1_addr), .bank1_wdata(bank1_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .fifo_cnt(fifo_cnt),
    .ovf_err(ovf_err), .unf_err(unf_err), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // sram: what the DUT actually wrote; sh: what the model says should be there
  logic [63:0] sram [2][2048];
  logic [63:0] sh   [2][2048];

  req_t        mq[$];
  logic        m_skid_v;
  req_t        m_skid;
  logic        m_ovf, m_unf, m_rdv;
  logic [63:0] m_rdd;
  int          m_cnt;

  int av_pct [6] = '{90, 50, 70, 30, 95, 60};
  int pv_pct [6] = '{30, 70, 50, 90, 10, 60};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_skid_v = 1'b0;
    m_skid   = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_rdv    = 1'b0;
    m_rdd    = '0;
    m_cnt    = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_bank0_cen", bank0_cen, 0);
    chk("rst_bank1_cen", bank1_cen, 0);
    chk("rst_bank0_wen", bank0_wen, 0);
    chk("rst_bank1_wen", bank1_wen, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_unf", unf_err, 0);
    chk("rst_conflict", conflict_cnt, 0);
  endtask

  // One clock: drive after the falling edge, check bank controls before the
  // rising edge, then check registered outputs just after it.
  task automatic step(input logic av, input logic bn, input logic [10:0] ma,
                      input logic pv, input logic [63:0] pd);
    req_t head, cand, inc;
    logic e_pop, e_cand, e_conf, e_issue;
    logic c0, w0, c1, w1;
    logic [10:0] a0, a1;
    logic [63:0] d0, d1;
    agu_valid    = av;
    BN_in        = bn;
    MA_in        = ma;
    pe_out_valid = pv;
    pe_out_data  = pd;
    inc.bn = bn;
    inc.ma = ma;
    e_pop  = pv && (mq.size() > 0);
    head   = e_pop ? mq[0] : '0;
    e_cand = m_skid_v || av;
    if (m_skid_v) cand = m_skid;
    else          cand = inc;
    e_conf  = e_cand && e_pop && (head.bn == cand.bn);
    e_issue = e_cand && !e_conf && ((mq.size() < DEPTH) || e_pop);
    #1;
    chk("bank0_cen", bank0_cen, (e_pop && !head.bn) || (e_issue && !cand.bn));
    chk("bank1_cen", bank1_cen, (e_pop && head.bn) || (e_issue && cand.bn));
    if (e_pop) begin
      if (!head.bn) begin
        chk("wb0_wen", bank0_wen, 1);
        chk("wb0_addr", bank0_addr, head.ma);
        chk("wb0_wdata", bank0_wdata, pd);
      end else begin
        chk("wb1_wen", bank1_wen, 1);
        chk("wb1_addr", bank1_addr, head.ma);
        chk("wb1_wdata", bank1_wdata, pd);
      end
    end
    if (e_issue) begin
      if (!cand.bn) begin
        chk("rd0_wen", bank0_wen, 0);
        chk("rd0_addr", bank0_addr, cand.ma);
      end else begin
        chk("rd1_wen", bank1_wen, 0);
        chk("rd1_addr", bank1_addr, cand.ma);
      end
    end
    c0 = bank0_cen; w0 = bank0_wen; a0 = bank0_addr; d0 = bank0_wdata;
    c1 = bank1_cen; w1 = bank1_wen; a1 = bank1_addr; d1 = bank1_wdata;
    @(posedge clk);
    if (c0) begin
      if (w0) sram[0][a0] = d0;
      else    bank0_rdata = sram[0][a0];
    end
    if (c1) begin
      if (w1) sram[1][a1] = d1;
      else    bank1_rdata = sram[1][a1];
    end
    if (pv && (mq.size() == 0)) m_unf = 1'b1;
    m_rdv = e_issue;
    if (e_issue) m_rdd = sh[cand.bn][cand.ma];
    if (e_pop) begin
      sh[head.bn][head.ma] = pd;
      mq.delete(0);
    end
    if (e_issue) mq.push_back(cand);
    if (m_skid_v) begin
      if (e_issue) begin
        m_skid_v = av;
        m_skid   = inc;
      end else if (e_conf) begin
        if (av) m_ovf = 1'b1;
      end else begin
        m_skid_v = 1'b0;
        m_ovf    = 1'b1;
      end
    end else if (av && !e_issue) begin
      if (e_conf) begin
        m_skid_v = 1'b1;
        m_skid   = inc;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1;
    chk("rd_valid", rd_valid, m_rdv);
    chk("rd_data", rd_data, m_rdd);
    chk("fifo_cnt", fifo_cnt, mq.size());
    chk("ovf_err", ovf_err, m_ovf);
    chk("unf_err", unf_err, m_unf);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 11'd0, 1'b0, 64'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    agu_valid    = 1'b0;
    BN_in        = 1'b0;
    MA_in        = '0;
    pe_out_valid = 1'b0;
    pe_out_data  = '0;
    bank0_rdata  = '0;
    bank1_rdata  = '0;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 2048; a++) begin
        sram[b][a] = {$urandom, $urandom};
        sh[b][a]   = sram[b][a];
      end
    end
    model_reset();
    #2;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single read on bank1
    step(1'b1, 1'b1, 11'h005, 1'b0, 64'd0);
    chk("single_cnt", fifo_cnt, 1);
    idle();
    step(1'b0, 1'b0, 11'd0, 1'b1, 64'h1234_5678_9abc_def0);

    // write-back in place
    step(1'b1, 1'b0, 11'h010, 1'b0, 64'd0);
    step(1'b0, 1'b0, 11'd0, 1'b1, 64'hDEAD);
    chk("wb_cnt_zero", fifo_cnt, 0);
    step(1'b1, 1'b0, 11'h010, 1'b0, 64'd0);
    chk("wb_readback", rd_data, 64'hDEAD);
    step(1'b0, 1'b0, 11'd0, 1'b1, 64'h5555);

    // bank conflict: write wins, read deferred through the skid
    step(1'b1, 1'b0, 11'h030, 1'b0, 64'd0);
    step(1'b1, 1'b0, 11'h020, 1'b1, 64'hBEEF);
    chk("conf_rd_valid_early", rd_valid, 0);
    step(1'b0, 1'b0, 11'd0, 1'b0, 64'd0);
    chk("conf_cnt", conflict_cnt, 1);
    idle();
    step(1'b0, 1'b0, 11'd0, 1'b1, 64'h7777);

    // overflow: fill, drop one, then simultaneous push/pop at full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 1'b0, 64'd0);
    chk("ovf_full", fifo_cnt, DEPTH);
    step(1'b1, 1'b1, 11'h3FF, 1'b0, 64'd0);
    chk("ovf_flag", ovf_err, 1);
    step(1'b1, 1'b1, 11'h3FE, 1'b1, {$urandom, $urandom});
    chk("ovf_pushpop_cnt", fifo_cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 11'd0, 1'b1, {$urandom, $urandom});

    // underflow is sticky
    step(1'b0, 1'b0, 11'd0, 1'b1, 64'hBAD);
    chk("unf_flag", unf_err, 1);
    idle();
    idle();

    // random traffic in phases of differing request/write-back mix
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(1, 100) <= av_pct[ph]), 1'($urandom_range(0, 1)),
             11'($urandom_range(0, 2047)),
             ($urandom_range(1, 100) <= pv_pct[ph]), {$urandom, $urandom});
      end
    end
    chk("sat_conflict", conflict_cnt, CMAX);

    // reset in the middle of traffic with the skid occupied
    for (int i = 0; i < 80 && (mq.size() > 0 || m_skid_v); i++)
      step(1'b0, 1'b0, 11'd0, 1'b1, {$urandom, $urandom});
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 11'(16 + i), 1'b0, 64'd0);
    step(1'b1, 1'b0, 11'h055, 1'b1, 64'hAAAA);
    chk("skid_loaded", m_skid_v, 1);
    agu_valid    = 1'b1;
    BN_in        = 1'b1;
    MA_in        = 11'h005;
    pe_out_valid = 1'b1;
    rst_n        = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n        = 1'b1;
    agu_valid    = 1'b0;
    pe_out_valid = 1'b0;
    step(1'b1, 1'b1, 11'h005, 1'b0, 64'd0);
    chk("post_rst_cnt", fifo_cnt, 1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
